// File: rtl/mem_arb.sv
// Shares the byte-wide RAM/IO port between the instruction and data caches.
// Serialises 1/2/4-byte accesses into byte transfers and returns a one-cycle done pulse.
module mem_arb #(
  parameter int               ADD_W   = 32,
  parameter int               DAT_W   = 32,
  parameter logic [ADD_W-1:0] IO_MASK = 32'h0003_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iIC_En,
  input  logic [ADD_W-1:0] iIC_Add,
  output logic             oIC_En,
  output logic [DAT_W-1:0] oIC_Dat,
  input  logic             iDC_En,
  input  logic             iDC_Rw,
  input  logic [2:0]       iDC_Len,
  input  logic [ADD_W-1:0] iDC_Add,
  input  logic [DAT_W-1:0] iDC_Dat,
  output logic             oDC_En,
  output logic [DAT_W-1:0] oDC_Dat,
  output logic             oRAM_Rw,
  output logic [ADD_W-1:0] oRAM_Add,
  output logic [7:0]       oRAM_Dat,
  input  logic [7:0]       iRAM_Dat,
  input  logic             iIO_Full,
  input  logic             iROB_Mp
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t           state_reg, state_next;
  logic             ic_pend_reg, ic_pend_next, dc_pend_reg, dc_pend_next;
  logic [ADD_W-1:0] icq_add_reg, icq_add_next, dcq_add_reg, dcq_add_next;
  logic             dcq_rw_reg, dcq_rw_next;
  logic [2:0]       dcq_len_reg, dcq_len_next;
  logic [DAT_W-1:0] dcq_dat_reg, dcq_dat_next;
  logic             owner_reg, owner_next;   // 1 = data cache
  logic [1:0]       last_reg, last_next;     // index of final byte
  logic [ADD_W-1:0] base_reg, base_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic [DAT_W-1:0] store_reg, store_next, asm_reg, asm_next, asm_ins;
  logic             ic_done_reg, ic_done_next, dc_done_reg, dc_done_next;
  logic [DAT_W-1:0] ic_rdat_reg, ic_rdat_next, dc_rdat_reg, dc_rdat_next;
  logic             ram_rw_reg, ram_rw_next;
  logic [ADD_W-1:0] ram_add_reg, ram_add_next;
  logic [7:0]       ram_wdat_reg, ram_wdat_next;
  logic [7:0]       st_byte [4];

  logic             ic_pulse_ok, dc_pulse_ok, dc_pend_ok, ic_req, dc_req;
  logic [ADD_W-1:0] ic_sel_add, dc_sel_add, nxt_add;
  logic             dc_sel_rw;
  logic [2:0]       dc_sel_len, cnt_inc;
  logic [DAT_W-1:0] dc_sel_dat;

  function automatic logic is_io(input logic [ADD_W-1:0] a);
    return (a & IO_MASK) == IO_MASK;
  endfunction

  function automatic logic [1:0] len_last(input logic [2:0] len);
    case (len)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // A flush drops fetches and loads but never a store.
  assign ic_pulse_ok = iIC_En && !ic_pend_reg && !iROB_Mp;
  assign dc_pulse_ok = iDC_En && !dc_pend_reg && !(iROB_Mp && !iDC_Rw);
  assign dc_pend_ok  = dc_pend_reg && !(iROB_Mp && !dcq_rw_reg);
  assign ic_req      = (ic_pend_reg && !iROB_Mp) || ic_pulse_ok;
  assign dc_req      = dc_pend_ok || dc_pulse_ok;
  assign ic_sel_add  = ic_pend_reg ? icq_add_reg : iIC_Add;
  assign dc_sel_add  = dc_pend_reg ? dcq_add_reg : iDC_Add;
  assign dc_sel_rw   = dc_pend_reg ? dcq_rw_reg  : iDC_Rw;
  assign dc_sel_len  = dc_pend_reg ? dcq_len_reg : iDC_Len;
  assign dc_sel_dat  = dc_pend_reg ? dcq_dat_reg : iDC_Dat;
  assign cnt_inc     = cnt_reg + 3'd1;
  assign nxt_add     = base_reg + ADD_W'(cnt_inc);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign st_byte[gi]         = store_reg[8*gi +: 8];
      // Byte captured while the counter is k+1 belongs to address base+k.
      assign asm_ins[8*gi +: 8]  = (cnt_reg == 3'(gi + 1)) ? iRAM_Dat : asm_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    ic_pend_next  = ic_pend_reg;
    dc_pend_next  = dc_pend_reg;
    icq_add_next  = icq_add_reg;
    dcq_add_next  = dcq_add_reg;
    dcq_rw_next   = dcq_rw_reg;
    dcq_len_next  = dcq_len_reg;
    dcq_dat_next  = dcq_dat_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    base_next     = base_reg;
    cnt_next      = cnt_reg;
    store_next    = store_reg;
    asm_next      = asm_reg;
    ic_done_next  = 1'b0;
    dc_done_next  = 1'b0;
    ic_rdat_next  = ic_rdat_reg;
    dc_rdat_next  = dc_rdat_reg;
    ram_rw_next   = ram_rw_reg;
    ram_add_next  = ram_add_reg;
    ram_wdat_next = ram_wdat_reg;
    if (!en) begin
      ram_rw_next = 1'b0;
    end else begin
      if (ic_pulse_ok) begin
        ic_pend_next = 1'b1;
        icq_add_next = iIC_Add;
      end else if (iROB_Mp) begin
        ic_pend_next = 1'b0;
      end
      if (dc_pulse_ok) begin
        dc_pend_next = 1'b1;
        dcq_add_next = iDC_Add;
        dcq_rw_next  = iDC_Rw;
        dcq_len_next = iDC_Len;
        dcq_dat_next = iDC_Dat;
      end else if (!dc_pend_ok) begin
        dc_pend_next = 1'b0;
      end
      case (state_reg)
        IDLE: begin
          ram_rw_next = 1'b0;
          cnt_next    = 3'd0;
          asm_next    = '0;
          if (dc_req) begin
            owner_next    = 1'b1;
            dc_pend_next  = 1'b0;
            base_next     = dc_sel_add;
            ram_add_next  = dc_sel_add;
            last_next     = len_last(dc_sel_len);
            store_next    = dc_sel_dat;
            ram_wdat_next = dc_sel_dat[7:0];
            if (dc_sel_rw) begin
              state_next  = WRITE;
              ram_rw_next = !(is_io(dc_sel_add) && iIO_Full);
            end else begin
              state_next  = READ;
            end
          end else if (ic_req) begin
            owner_next   = 1'b0;
            ic_pend_next = 1'b0;
            base_next    = ic_sel_add;
            ram_add_next = ic_sel_add;
            last_next    = 2'd3;
            state_next   = READ;
          end
        end
        READ: begin
          if (iROB_Mp) begin
            state_next = IDLE;
          end else if (cnt_reg == {1'b0, last_reg} + 3'd1) begin
            state_next = IDLE;
            if (owner_reg) begin
              dc_done_next = 1'b1;
              dc_rdat_next = asm_ins;
            end else begin
              ic_done_next = 1'b1;
              ic_rdat_next = asm_ins;
            end
          end else begin
            asm_next = asm_ins;
            cnt_next = cnt_inc;
            if (cnt_reg[1:0] != last_reg) ram_add_next = nxt_add;
          end
        end
        WRITE: begin
          // ram_rw_reg high means the current byte went out this cycle.
          if (ram_rw_reg) begin
            if (cnt_reg[1:0] == last_reg) begin
              ram_rw_next  = 1'b0;
              dc_done_next = 1'b1;
              dc_rdat_next = '0;
              state_next   = IDLE;
            end else begin
              cnt_next      = cnt_inc;
              ram_add_next  = nxt_add;
              ram_wdat_next = st_byte[cnt_inc[1:0]];
              ram_rw_next   = !(is_io(nxt_add) && iIO_Full);
            end
          end else begin
            ram_rw_next = !(is_io(ram_add_reg) && iIO_Full);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ic_pend_reg  <= 1'b0;
      dc_pend_reg  <= 1'b0;
      icq_add_reg  <= '0;
      dcq_add_reg  <= '0;
      dcq_rw_reg   <= 1'b0;
      dcq_len_reg  <= '0;
      dcq_dat_reg  <= '0;
      owner_reg    <= 1'b0;
      last_reg     <= '0;
      base_reg     <= '0;
      cnt_reg      <= '0;
      store_reg    <= '0;
      asm_reg      <= '0;
      ic_done_reg  <= 1'b0;
      dc_done_reg  <= 1'b0;
      ic_rdat_reg  <= '0;
      dc_rdat_reg  <= '0;
      ram_rw_reg   <= 1'b0;
      ram_add_reg  <= '0;
      ram_wdat_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ic_pend_reg  <= ic_pend_next;
      dc_pend_reg  <= dc_pend_next;
      icq_add_reg  <= icq_add_next;
      dcq_add_reg  <= dcq_add_next;
      dcq_rw_reg   <= dcq_rw_next;
      dcq_len_reg  <= dcq_len_next;
      dcq_dat_reg  <= dcq_dat_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      base_reg     <= base_next;
      cnt_reg      <= cnt_next;
      store_reg    <= store_next;
      asm_reg      <= asm_next;
      ic_done_reg  <= ic_done_next;
      dc_done_reg  <= dc_done_next;
      ic_rdat_reg  <= ic_rdat_next;
      dc_rdat_reg  <= dc_rdat_next;
      ram_rw_reg   <= ram_rw_next;
      ram_add_reg  <= ram_add_next;
      ram_wdat_reg <= ram_wdat_next;
    end
  end

  assign oIC_En   = ic_done_reg;
  assign oIC_Dat  = ic_rdat_reg;
  assign oDC_En   = dc_done_reg;
  assign oDC_Dat  = dc_rdat_reg;
  assign oRAM_Rw  = ram_rw_reg;
  assign oRAM_Add = ram_add_reg;
  assign oRAM_Dat = ram_wdat_reg;
endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: expected completions are queued at request time
// and popped when the done pulses appear; a byte RAM model answers reads.
module tb_mem_arb;
  logic        clk = 1'b0, rst, en;
  logic        iIC_En, iDC_En, iDC_Rw, iIO_Full, iROB_Mp;
  logic [31:0] iIC_Add, iDC_Add, iDC_Dat;
  logic [2:0]  iDC_Len;
  logic        oIC_En, oDC_En, oRAM_Rw;
  logic [31:0] oIC_Dat, oDC_Dat, oRAM_Add;
  logic [7:0]  oRAM_Dat, iRAM_Dat;

  typedef struct {logic [31:0] dat; int cyc;} exp_t;
  exp_t ic_q[$], dc_q[$];
  exp_t e_ic, e_dc;
  int   n_checks = 0, n_errors = 0, cyc = 0, t0;
  logic [7:0] wmem [logic [31:0]];

  mem_arb dut (
    .clk(clk), .rst(rst), .en(en),
    .iIC_En(iIC_En), .iIC_Add(iIC_Add), .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
    .iDC_En(iDC_En), .iDC_Rw(iDC_Rw), .iDC_Len(iDC_Len), .iDC_Add(iDC_Add), .iDC_Dat(iDC_Dat),
    .oDC_En(oDC_En), .oDC_Dat(oDC_Dat),
    .oRAM_Rw(oRAM_Rw), .oRAM_Add(oRAM_Add), .oRAM_Dat(oRAM_Dat), .iRAM_Dat(iRAM_Dat),
    .iIO_Full(iIO_Full), .iROB_Mp(iROB_Mp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h010: return 8'hA5;
      32'h000: return 8'h11;
      32'h001: return 8'h22;
      32'h002: return 8'h33;
      32'h003: return 8'h44;
      32'h202: return 8'h77;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] peek(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : init_byte(a);
  endfunction

  // Read data valid one cycle after its address; writes land at the clock edge.
  always @(posedge clk) begin
    logic [7:0] rd;
    rd = peek(oRAM_Add);
    if (oRAM_Rw) wmem[oRAM_Add] = oRAM_Dat;
    iRAM_Dat <= rd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((ic_q.size() != 0 || dc_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", ic_q.size() + dc_q.size(), 0);
    repeat (4) tick();
  endtask

  always @(negedge clk) begin
    if (!rst && oIC_En) begin
      if (ic_q.size() == 0) chk("ic_unexpected_done", 1, 0);
      else begin
        e_ic = ic_q.pop_front();
        $display("txn ic done data=%h cycle=%0d", oIC_Dat, cyc);
        chk("ic_data", oIC_Dat, e_ic.dat);
        chk("ic_cycle", cyc, e_ic.cyc);
      end
    end
    if (!rst && oDC_En) begin
      if (dc_q.size() == 0) chk("dc_unexpected_done", 1, 0);
      else begin
        e_dc = dc_q.pop_front();
        $display("txn dc done data=%h cycle=%0d", oDC_Dat, cyc);
        chk("dc_data", oDC_Dat, e_dc.dat);
        chk("dc_cycle", cyc, e_dc.cyc);
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ic_en"}, oIC_En, 0);
    chk({tag, "_ic_dat"}, oIC_Dat, 0);
    chk({tag, "_dc_en"}, oDC_En, 0);
    chk({tag, "_dc_dat"}, oDC_Dat, 0);
    chk({tag, "_rw"}, oRAM_Rw, 0);
    chk({tag, "_add"}, oRAM_Add, 0);
    chk({tag, "_wdat"}, oRAM_Dat, 0);
  endtask

  initial begin
    rst = 1; en = 1; iIC_En = 0; iDC_En = 0; iDC_Rw = 0; iIO_Full = 0; iROB_Mp = 0;
    iIC_Add = 0; iDC_Add = 0; iDC_Dat = 0; iDC_Len = 0;
    tick(); tick();
    @(negedge clk); chk_idle_outputs("reset");
    tick(); rst = 0;
    tick();

    // IC fetch of 4 bytes at 0x100
    t0 = cyc; iIC_En = 1; iIC_Add = 32'h100; ic_q.push_back('{32'h0000_0513, t0 + 6});
    tick(); iIC_En = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_add", oRAM_Add, 32'h100 + k);
      chk("fetch_rw", oRAM_Rw, 0);
      tick();
    end
    drain();

    // DC write Len=2
    t0 = cyc; iDC_En = 1; iDC_Rw = 1; iDC_Len = 2; iDC_Add = 32'h200; iDC_Dat = 32'hDEAD_BEEF;
    dc_q.push_back('{32'h0, t0 + 3});
    tick(); iDC_En = 0;
    @(negedge clk); chk("wr0_rw", oRAM_Rw, 1); chk("wr0_add", oRAM_Add, 32'h200); chk("wr0_dat", oRAM_Dat, 8'hEF);
    tick();
    @(negedge clk); chk("wr1_rw", oRAM_Rw, 1); chk("wr1_add", oRAM_Add, 32'h201); chk("wr1_dat", oRAM_Dat, 8'hBE);
    drain();
    chk("mem_200", peek(32'h200), 8'hEF);
    chk("mem_201", peek(32'h201), 8'hBE);
    chk("mem_202_untouched", peek(32'h202), 8'h77);

    // Simultaneous IC fetch and DC byte read: DC first
    t0 = cyc; iIC_En = 1; iIC_Add = 32'h0; iDC_En = 1; iDC_Rw = 0; iDC_Len = 1; iDC_Add = 32'h10;
    dc_q.push_back('{32'h0000_00A5, t0 + 3});
    ic_q.push_back('{32'h4433_2211, t0 + 9});
    tick(); iIC_En = 0; iDC_En = 0;
    @(negedge clk); chk("prio_dc_add", oRAM_Add, 32'h10);
    repeat (3) tick();
    @(negedge clk); chk("prio_ic_add", oRAM_Add, 32'h0); chk("prio_ic_rw", oRAM_Rw, 0);
    drain();

    // DC read with Len=3 (treated as 4) wrapping past the top of memory
    t0 = cyc; iDC_En = 1; iDC_Rw = 0; iDC_Len = 3; iDC_Add = 32'hFFFF_FFFE;
    dc_q.push_back('{32'h2211_BBAA, t0 + 6});
    tick(); iDC_En = 0;
    @(negedge clk); chk("wrap_add0", oRAM_Add, 32'hFFFF_FFFE);
    tick();
    @(negedge clk); chk("wrap_add1", oRAM_Add, 32'hFFFF_FFFF);
    tick();
    @(negedge clk); chk("wrap_add2", oRAM_Add, 32'h0);
    drain();

    // IO write held off by a full output buffer
    t0 = cyc; iDC_En = 1; iDC_Rw = 1; iDC_Len = 1; iDC_Add = 32'h0003_0000; iDC_Dat = 32'h41;
    iIO_Full = 1;
    tick(); iDC_En = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); chk("io_stall_rw", oRAM_Rw, 0);
      tick();
      if (i == 4) iIO_Full = 0;
    end
    dc_q.push_back('{32'h0, cyc + 1});
    @(negedge clk);
    chk("io_rel_rw", oRAM_Rw, 1); chk("io_rel_add", oRAM_Add, 32'h0003_0000); chk("io_rel_dat", oRAM_Dat, 8'h41);
    drain();

    // Misprediction during IC fetch byte 2 with a DC write pending
    t0 = cyc; iIC_En = 1; iIC_Add = 32'h100;
    tick(); iIC_En = 0;
    iDC_En = 1; iDC_Rw = 1; iDC_Len = 1; iDC_Add = 32'h300; iDC_Dat = 32'h5A;
    dc_q.push_back('{32'h0, t0 + 6});
    tick(); iDC_En = 0;
    tick(); iROB_Mp = 1;
    @(negedge clk); chk("mp_byte2_add", oRAM_Add, 32'h102);
    tick(); iROB_Mp = 0;
    tick();
    @(negedge clk); chk("mp_wr_rw", oRAM_Rw, 1); chk("mp_wr_add", oRAM_Add, 32'h300);
    drain();
    chk("mem_300", peek(32'h300), 8'h5A);

    // Reset in the middle of a write, then a fetch as from reset
    iDC_En = 1; iDC_Rw = 1; iDC_Len = 4; iDC_Add = 32'h400; iDC_Dat = 32'h0102_0304;
    tick(); iDC_En = 0;
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk); chk_idle_outputs("midrst");
    tick();
    t0 = cyc; iIC_En = 1; iIC_Add = 32'h100; ic_q.push_back('{32'h0000_0513, t0 + 6});
    tick(); iIC_En = 0;
    @(negedge clk); chk("post_rst_add", oRAM_Add, 32'h100); chk("post_rst_rw", oRAM_Rw, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Memory-side controller and arbiter that shares the single byte-wide RAM/IO port between the instruction cache and the data cache. It latches one-cycle request pulses from both caches, grants the port to one at a time, serialises 1/2/4-byte accesses into byte transfers, assembles little-endian read data and returns a one-cycle completion pulse. It sits between the two caches and the top-level memory pins, and handles misprediction flush and IO back-pressure.

## Interface
- ADD_W, 32, address width
- DAT_W, 32, cache-side data width
- IO_MASK, 32'h0003_0000, address bits that mark an IO access (all set means IO)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global ready; low freezes all state
- iIC_En  in  1  fetch request pulse (always 4 bytes)
- iIC_Add  in  ADD_W  fetch address
- oIC_En  out  1  fetch done pulse
- oIC_Dat  out  DAT_W  fetched word
- iDC_En  in  1  data request pulse
- iDC_Rw  in  1  0 read, 1 write
- iDC_Len  in  3  byte count: 1, 2 or 4
- iDC_Add  in  ADD_W  data address
- iDC_Dat  in  DAT_W  store data (low Len bytes used)
- oDC_En  out  1  data done pulse (reads and writes)
- oDC_Dat  out  DAT_W  load data, zero-extended
- oRAM_Rw  out  1  0 read, 1 write
- oRAM_Add  out  ADD_W  byte address
- oRAM_Dat  out  8  write byte
- iRAM_Dat  in  8  read byte, valid one cycle after its address
- iIO_Full  in  1  IO output buffer full
- iROB_Mp  in  1  misprediction flush

## Operation
- Reset: all outputs 0, state IDLE, both pending flags 0, byte counter 0.
- Pending flags: pulse on iIC_En/iDC_En sets icPend/dcPend and latches address/rw/len/data. A pulse while the same flag is set is ignored.
- States: IDLE, READ, WRITE.
- IDLE: effective request = pending flag OR same-cycle pulse. Priority is DC over IC. On a DC write, go to WRITE; on a DC read or IC fetch, go to READ. The owner, N and base address are registered and the pending flag is cleared. oRAM_Rw is 0.
- READ: byte k (k=0..N-1) address base+k is driven in consecutive cycles. Byte k is captured from iRAM_Dat one cycle later into bits [8k+7:8k]. Upper bytes are 0 when N<4. After the last capture, the owner's done pulse and data are registered and the FSM returns to IDLE.
- WRITE: one cycle per byte. oRAM_Rw=1, oRAM_Add=base+k, oRAM_Dat=store[8k+7:8k]. After byte N-1, oRAM_Rw<=0, oDC_En<=1, oDC_Dat<=0, and the FSM goes to IDLE.
- IO stall: if the write address matches IO_MASK and iIO_Full=1, hold in WRITE with oRAM_Rw=0 and the counter frozen. Resume when iIO_Full=0.
- Address arithmetic: base+k is computed modulo 2^ADD_W. Wrap at 32'hFFFF_FFFF goes to 0.
- iROB_Mp=1 (sampled when en=1):
  - clears icPend and any IC fetch in READ with no oIC_En; return to IDLE.
  - clears a pending DC read and any DC read in READ with no oDC_En.
  - does not affect a DC write in progress or pending; writes are committed stores.
  - a DC write pulse in the same cycle is accepted.
  - an IC/DC-read pulse in the same cycle is dropped.
- en=0: no state change; oRAM_Rw forced 0; done pulses are not generated.
- iDC_Len values other than 1/2/4 are treated as 4.

## Timing
- Cycles are counted from T, the cycle in which the request is presented while IDLE with no higher-priority request.
- Read of N bytes: first address in T+1, last address in T+N, done pulse in T+N+2. The IC fetch pulse is at T+6.
- Write of N bytes: writes in T+1..T+N, oDC_En in T+N+1, plus stall cycles.
- Done pulses are exactly one cycle wide; data is valid in the same cycle.
- The completion cycle is IDLE. The next pending request's first address appears in the cycle after completion.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- IC fetch at 0x100 with RAM bytes 13,05,00,00 -> addresses 0x100..0x103 in T+1..T+4; oIC_En=1 with oIC_Dat=32'h0000_0513 at T+6.
- DC write Len=2 at 0x200 with data 32'hDEAD_BEEF -> writes EF@0x200 and BE@0x201, Rw=1 for 2 cycles; oDC_En at T+3; byte 0x202 untouched.
- Simultaneous iIC_En(0x0) and iDC_En read Len=1 at 0x10 -> DC served first, with oDC_Dat zero-extended byte at T+3. IC addresses start at T+4; oIC_En at T+9.
- Write 0x41 to 0x30000 with iIO_Full=1 for 5 cycles -> oRAM_Rw=0 throughout. On release, one write cycle and oDC_En the following cycle.
- iROB_Mp during IC fetch byte 2 with a DC write pending -> no oIC_En; the DC write runs to completion with oDC_En.
- rst asserted mid-WRITE -> next cycle all outputs 0 and FSM IDLE; a later request behaves as from reset.
